// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one aligned read at a time and
// holds the returned word for the decoder behind a valid/ready handshake.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP,
      ST_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] redirect_target;

   assign redirect_target = redirect_pc & ~32'h3;

   // NOTE: all state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC & ~32'h3;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_data_q <= inst_data_d;
         inst_pc_q   <= inst_pc_d;
      end
   end

   // NOTE: every _d defaults to its _q first, so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redirect_target;
         end

         ST_REQ: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = imem_req_ready ? ST_DROP : ST_REQ;
            end else if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = imem_resp_valid ? ST_REQ : ST_DROP;
            end else if (imem_resp_valid) begin
               inst_data_d = imem_resp_data;
               inst_pc_d   = pc_q;
               state_d     = ST_HOLD;
            end
         end

         // The squashed request is still in flight; its response is swallowed here.
         ST_DROP: begin
            if (redirect_valid) pc_d = redirect_target;
            if (imem_resp_valid) state_d = ST_REQ;
         end

         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = ST_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign imem_req_valid = (state_q == ST_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == ST_HOLD);
   assign inst_data      = inst_data_q;
   assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, a wrap/reset sequence, then random
// traffic scored against an architectural next-PC model and a latency-varying memory.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc)
   );

   typedef struct {
      logic        rst;
      logic        rr;
      logic        rv;
      logic [31:0] rd;
      logic        dv;
      logic [31:0] dpc;
      logic        ir;
      logic        chk;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_ipc;
      logic [31:0] e_idata;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic vec_t v(input logic rst, input logic rr, input logic rv,
                              input logic [31:0] rd, input logic dv, input logic [31:0] dpc,
                              input logic ir, input logic chk, input logic e_req,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic [31:0] e_idata);
      vec_t r;
      r.rst = rst; r.rr = rr; r.rv = rv; r.rd = rd; r.dv = dv; r.dpc = dpc; r.ir = ir;
      r.chk = chk; r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv;
      r.e_ipc = e_ipc; r.e_idata = e_idata;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic rr, input logic rv, input logic [31:0] rd,
                        input logic dv, input logic [31:0] dpc, input logic ir);
      rst_n           = rst;
      imem_req_ready  = rr;
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      redirect_valid  = dv;
      redirect_pc     = dpc;
      inst_ready      = ir;
   endtask

   task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_iv, input logic [31:0] e_ipc,
                             input logic [31:0] e_idata);
      check({tag, "_req_valid"}, imem_req_valid, e_req);
      if (e_req) check({tag, "_req_addr"}, imem_req_addr, e_addr);
      check({tag, "_inst_valid"}, inst_valid, e_iv);
      check({tag, "_inst_pc"}, inst_pc, e_ipc);
      check({tag, "_inst_data"}, inst_data, e_idata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w100, w104, w108, w200, w300, w1000, w2000, w2004, junk, wtop, w0;
      logic [31:0] exp_pc, paddr, tgt;
      logic        pending, rr, rv, dv, ir;
      logic [31:0] rd, dpc;
      int          pcnt, since, handshakes;

      w100  = mem_word(32'h100);  w104  = mem_word(32'h104);  w108 = mem_word(32'h108);
      w200  = mem_word(32'h200);  w300  = mem_word(32'h300);
      w1000 = mem_word(32'h1000); w2000 = mem_word(32'h2000); w2004 = mem_word(32'h2004);
      wtop  = mem_word(32'hFFFF_FFFC); w0 = mem_word(32'h0);
      junk  = 32'hDEAD_BEEF;

      // Each row: inputs applied for one cycle, outputs expected during that cycle.
      vecs.push_back(v(0,0,0,0,    0,0,0, 0, 0,0,0,0,0));
      vecs.push_back(v(1,0,0,0,    0,0,0, 1, 0,0,0,0,0));
      vecs.push_back(v(1,1,0,0,    0,0,0, 1, 1,32'h100,0,0,0));
      vecs.push_back(v(1,0,1,w100, 0,0,0, 1, 0,0,0,0,0));
      vecs.push_back(v(1,0,0,0,    0,0,1, 1, 0,0,1,32'h100,w100));
      vecs.push_back(v(1,1,0,0,    0,0,0, 1, 1,32'h104,0,32'h100,w100));
      vecs.push_back(v(1,0,1,w104, 0,0,0, 1, 0,0,0,32'h100,w100));
      for (int i = 7; i <= 11; i++)
         vecs.push_back(v(1,1,(i == 9),junk, 0,0,0, 1, 0,0,1,32'h104,w104));
      vecs.push_back(v(1,0,0,0,    0,0,1, 1, 0,0,1,32'h104,w104));
      vecs.push_back(v(1,0,0,0,    0,0,0, 1, 1,32'h108,0,32'h104,w104));
      vecs.push_back(v(1,1,0,0,    0,0,0, 1, 1,32'h108,0,32'h104,w104));
      vecs.push_back(v(1,0,0,0,    1,32'h203,0, 1, 0,0,0,32'h104,w104));
      vecs.push_back(v(1,1,0,0,    0,0,1, 1, 0,0,0,32'h104,w104));
      vecs.push_back(v(1,1,1,w108, 0,0,1, 1, 0,0,0,32'h104,w104));
      vecs.push_back(v(1,1,0,0,    0,0,1, 1, 1,32'h200,0,32'h104,w104));
      vecs.push_back(v(1,0,1,w200, 1,32'h300,1, 1, 0,0,0,32'h104,w104));
      vecs.push_back(v(1,1,0,0,    0,0,1, 1, 1,32'h300,0,32'h104,w104));
      vecs.push_back(v(1,0,1,w300, 0,0,1, 1, 0,0,0,32'h104,w104));
      vecs.push_back(v(1,0,0,0,    1,32'h400,1, 1, 0,0,1,32'h300,w300));
      vecs.push_back(v(1,0,0,0,    1,32'h1000,0, 1, 1,32'h400,0,32'h300,w300));
      vecs.push_back(v(1,1,0,0,    1,32'h2000,0, 1, 1,32'h1000,0,32'h300,w300));
      vecs.push_back(v(1,0,1,w1000,0,0,0, 1, 0,0,0,32'h300,w300));
      vecs.push_back(v(1,1,0,0,    0,0,0, 1, 1,32'h2000,0,32'h300,w300));
      vecs.push_back(v(1,0,1,w2000,0,0,0, 1, 0,0,0,32'h300,w300));
      vecs.push_back(v(1,0,0,0,    0,0,1, 1, 0,0,1,32'h2000,w2000));
      vecs.push_back(v(1,1,0,0,    1,32'h3000,0, 1, 1,32'h2004,0,32'h2000,w2000));
      vecs.push_back(v(1,0,0,0,    1,32'h4000,0, 1, 0,0,0,32'h2000,w2000));
      vecs.push_back(v(1,0,1,w2004,1,32'h5002,0, 1, 0,0,0,32'h2000,w2000));
      vecs.push_back(v(1,0,0,0,    0,0,0, 1, 1,32'h5000,0,32'h2000,w2000));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].dv, vecs[i].dpc,
               vecs[i].ir);
         if (vecs[i].chk)
            expect_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                       vecs[i].e_ipc, vecs[i].e_idata);
      end

      // PC wrap at the top of the address space, then reset during an outstanding fetch.
      @(negedge clk); drive(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
      expect_out("wrap_a", 1, 32'h5000, 0, 32'h2000, w2000);
      @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0);
      expect_out("wrap_b", 1, 32'hFFFF_FFFC, 0, 32'h2000, w2000);
      @(negedge clk); drive(1, 0, 1, wtop, 0, 0, 0);
      expect_out("wrap_c", 0, 0, 0, 32'h2000, w2000);
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1);
      expect_out("wrap_d", 0, 0, 1, 32'hFFFF_FFFC, wtop);
      @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0);
      expect_out("wrap_e", 1, 32'h0, 0, 32'hFFFF_FFFC, wtop);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("rstmid_wait", 0, 0, 0, 32'hFFFF_FFFC, wtop);
      @(negedge clk); drive(1, 0, 1, w0, 0, 0, 0);
      expect_out("rstmid_idle", 0, 0, 0, 0, 0);
      @(negedge clk); drive(1, 0, 1, w0, 0, 0, 0);
      expect_out("rstmid_req", 1, RST_PC, 0, 0, 0);
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
      expect_out("rstmid_req2", 1, RST_PC, 0, 0, 0);

      // Random traffic: memory with 1..4 cycle latency, spurious pulses when idle.
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
      exp_pc = RST_PC; pending = 1'b0; paddr = '0; pcnt = 0; since = 0; handshakes = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rv = 1'b0; rd = '0;
         if (pending && pcnt == 0) begin
            rv = 1'b1; rd = mem_word(paddr);
         end else if (!pending && $urandom_range(15) == 0) begin
            rv = 1'b1; rd = $urandom;
         end
         rr  = ($urandom_range(3) != 0);
         dv  = ($urandom_range(19) == 0);
         dpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                        : 32'($urandom);
         ir  = ($urandom_range(2) != 0);
         drive(1, rr, rv, rd, dv, dpc, ir);
         tgt = {dpc[31:2], 2'b00};

         if (imem_req_valid) begin
            check("rnd_one_outstanding", 32'(pending), 0);
            check("rnd_addr_aligned", 32'(imem_req_addr[1:0]), 0);
            if (rr && !dv) check("rnd_req_addr", imem_req_addr, exp_pc);
         end
         if (inst_valid && ir) begin
            check("rnd_inst_pc", inst_pc, exp_pc);
            check("rnd_inst_data", inst_data, mem_word(exp_pc));
            exp_pc = dv ? tgt : exp_pc + 32'd4;
            since = 0;
            handshakes++;
         end else if (dv) begin
            exp_pc = tgt;
         end

         if (pending) begin
            if (pcnt == 0) pending = 1'b0;
            else pcnt--;
         end
         if (imem_req_valid && rr) begin
            pending = 1'b1; paddr = imem_req_addr; pcnt = $urandom_range(3);
         end

         since++;
         if (since > 400) begin
            checks++; errors++;
            $display("FAIL rnd_progress: got %0d idle cycles, expected at most 400", since);
            break;
         end
      end
      check("rnd_handshakes_seen", 32'(handshakes > 100), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
